// File: rtl/obstacle_logic_if.sv
// Bus between the obstacle scroller / game top level and the collision referee.
// Carries an extra Score output when OBSTACLE_SCORE_EN is defined.
interface obstacle_logic_if;
   logic              Start;
   logic              Ack;
   logic [9:0]        X_Edge;
   logic [9:0]        Y_Edge;
   logic signed [9:0] Bird_X;
   logic signed [9:0] Bird_Y;
   logic              Q_Initial;
   logic              Q_Check;
   logic              Q_Lose;
   logic              Lose;
   logic              Check;
   logic [9:0]        X_left_edge;
   logic [9:0]        X_right_edge;
   logic [9:0]        Y_top_edge;
   logic [9:0]        Y_bottom_edge;
`ifdef OBSTACLE_SCORE_EN
   logic [3:0]        Score;

   modport master (
      output Start, Ack, X_Edge, Y_Edge, Bird_X, Bird_Y,
      input  Q_Initial, Q_Check, Q_Lose, Lose, Check,
      input  X_left_edge, X_right_edge, Y_top_edge, Y_bottom_edge, Score
   );
   modport slave (
      input  Start, Ack, X_Edge, Y_Edge, Bird_X, Bird_Y,
      output Q_Initial, Q_Check, Q_Lose, Lose, Check,
      output X_left_edge, X_right_edge, Y_top_edge, Y_bottom_edge, Score
   );
`else
   modport master (
      output Start, Ack, X_Edge, Y_Edge, Bird_X, Bird_Y,
      input  Q_Initial, Q_Check, Q_Lose, Lose, Check,
      input  X_left_edge, X_right_edge, Y_top_edge, Y_bottom_edge
   );
   modport slave (
      input  Start, Ack, X_Edge, Y_Edge, Bird_X, Bird_Y,
      output Q_Initial, Q_Check, Q_Lose, Lose, Check,
      output X_left_edge, X_right_edge, Y_top_edge, Y_bottom_edge
   );
`endif
endinterface

// File: rtl/obstacle_logic.sv
// Flappy collision referee: INITIAL/CHECK/LOSE phase FSM, registered pipe edges,
// per-clock hit test. Define OBSTACLE_SCORE_EN to add the saturating pipe-pass Score counter.
module obstacle_logic #(
   parameter int OBS_W    = 60,
   parameter int GAP_H    = 120,
   parameter int BIRD_W   = 16,
   parameter int BIRD_H   = 16,
   parameter int SCREEN_H = 480
) (
   input logic           Clk,
   input logic           reset,
   obstacle_logic_if.slave bus
);
   typedef enum logic [2:0] {
      INITIAL = 3'b001,
      CHECK   = 3'b010,
      LOSE    = 3'b100
   } state_t;

   localparam logic signed [11:0] OBS_W_S    = 12'(OBS_W);
   localparam logic signed [11:0] GAP_H_S    = 12'(GAP_H);
   localparam logic signed [11:0] BIRD_W_S   = 12'(BIRD_W);
   localparam logic signed [11:0] BIRD_H_S   = 12'(BIRD_H);
   localparam logic signed [11:0] SCREEN_H_S = 12'(SCREEN_H);

   state_t state;

   logic signed [11:0] xe, ye, bx, by;
   logic               hx, in_gap, off, hit, safe;

   // Edges are unsigned pixel positions, the bird may sit above the screen (negative y).
   assign xe = signed'({2'b00, bus.X_Edge});
   assign ye = signed'({2'b00, bus.Y_Edge});
   assign bx = signed'({{2{bus.Bird_X[9]}}, bus.Bird_X});
   assign by = signed'({{2{bus.Bird_Y[9]}}, bus.Bird_Y});

   assign hx     = ((bx + BIRD_W_S) > xe) && (bx < (xe + OBS_W_S));
   assign in_gap = (by >= ye) && ((by + BIRD_H_S) <= (ye + GAP_H_S));
   assign off    = (by < 12'sd0) || ((by + BIRD_H_S) > SCREEN_H_S);
   assign hit    = (hx && !in_gap) || off;
   assign safe   = hx && in_gap && !off;

   assign bus.Q_Initial = state[0];
   assign bus.Q_Check   = state[1];
   assign bus.Q_Lose    = state[2];

   always_ff @(posedge Clk) begin
      if (reset) begin
         state             <= INITIAL;
         bus.Lose          <= 1'b0;
         bus.Check         <= 1'b0;
         bus.X_left_edge   <= '0;
         bus.X_right_edge  <= '0;
         bus.Y_top_edge    <= '0;
         bus.Y_bottom_edge <= '0;
      end else begin
         bus.X_left_edge   <= bus.X_Edge;
         bus.X_right_edge  <= bus.X_Edge + 10'(OBS_W);
         bus.Y_top_edge    <= bus.Y_Edge;
         bus.Y_bottom_edge <= bus.Y_Edge + 10'(GAP_H);
         bus.Lose          <= 1'b0;
         bus.Check         <= 1'b0;
         case (state)
            INITIAL: if (bus.Start) state <= CHECK;
            CHECK: begin
               bus.Check <= safe;
               if (hit) begin
                  state    <= LOSE;
                  bus.Lose <= 1'b1;
               end
            end
            LOSE:    if (bus.Ack) state <= INITIAL;
            default: state <= INITIAL;
         endcase
      end
   end

`ifdef OBSTACLE_SCORE_EN
   logic passed, passed_r;

   // A pipe counts once, on the clock its right edge first falls left of the bird.
   assign passed = (xe + OBS_W_S) < bx;

   always_ff @(posedge Clk) begin
      if (reset) begin
         bus.Score <= 4'd0;
         passed_r  <= 1'b0;
      end else begin
         passed_r <= passed;
         if (state == INITIAL && bus.Start)
            bus.Score <= 4'd0;
         else if (state == CHECK && passed && !passed_r && bus.Score != 4'd15)
            bus.Score <= bus.Score + 4'd1;
      end
   end
`else
   // Scoring disabled: no counter is built.
`endif

endmodule

// File: tb/tb_obstacle_logic.sv
// Scoreboard bench for obstacle_logic: stimulus pushes expected outputs from a
// rule-level game model, a monitor pops and compares one entry per clock.
module tb_obstacle_logic;
   logic Clk = 1'b0;
   logic reset;

   obstacle_logic_if bus ();

   obstacle_logic dut (
      .Clk   (Clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       qi, qc, ql, lose, chk;
      logic [9:0] xl, xr, yt, yb;
      int         tag;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   step_no = 0;

   // Game phase of the reference model: 0 = waiting, 1 = playing, 2 = lost.
   int   phase = 0;

   task automatic drive(input logic r, input logic s, input logic a,
                        input int xe_in, input int ye_in, input int bx_in, input int by_in);
      exp_t e;
      logic [9:0]        xe10, ye10;
      logic signed [9:0] bx10, by10;
      int xe, ye, bx, by;
      bit hx, ing, off, hit;
      @(negedge Clk);
      xe10 = 10'(xe_in);
      ye10 = 10'(ye_in);
      bx10 = 10'(bx_in);
      by10 = 10'(by_in);
      reset = r; bus.Start = s; bus.Ack = a;
      bus.X_Edge = xe10; bus.Y_Edge = ye10; bus.Bird_X = bx10; bus.Bird_Y = by10;
      xe = int'(xe10); ye = int'(ye10); bx = int'(bx10); by = int'(by10);
      hx  = (bx + 16 > xe) && (bx < xe + 60);
      ing = (by >= ye) && (by + 16 <= ye + 120);
      off = (by < 0) || (by + 16 > 480);
      hit = (hx && !ing) || off;
      e.lose = 1'b0; e.chk = 1'b0;
      if (r) begin
         phase = 0;
         e.xl = '0; e.xr = '0; e.yt = '0; e.yb = '0;
      end else begin
         e.xl = xe10;
         e.xr = 10'((xe + 60) % 1024);
         e.yt = ye10;
         e.yb = 10'((ye + 120) % 1024);
         if (phase == 0) begin
            if (s) phase = 1;
         end else if (phase == 1) begin
            e.chk = hx && ing && !off;
            if (hit) begin
               phase  = 2;
               e.lose = 1'b1;
            end
         end else begin
            if (a) phase = 0;
         end
      end
      e.qi = (phase == 0);
      e.qc = (phase == 1);
      e.ql = (phase == 2);
      step_no++;
      e.tag = step_no;
      sb.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({bus.Q_Initial, bus.Q_Check, bus.Q_Lose, bus.Lose, bus.Check} !==
                {e.qi, e.qc, e.ql, e.lose, e.chk} ||
                bus.X_left_edge !== e.xl || bus.X_right_edge !== e.xr ||
                bus.Y_top_edge !== e.yt || bus.Y_bottom_edge !== e.yb) begin
               errors++;
               $display("FAIL step%0d got q=%b%b%b lose=%b chk=%b edges=%0d/%0d/%0d/%0d required q=%b%b%b lose=%b chk=%b edges=%0d/%0d/%0d/%0d",
                        e.tag, bus.Q_Initial, bus.Q_Check, bus.Q_Lose, bus.Lose, bus.Check,
                        bus.X_left_edge, bus.X_right_edge, bus.Y_top_edge, bus.Y_bottom_edge,
                        e.qi, e.qc, e.ql, e.lose, e.chk, e.xl, e.xr, e.yt, e.yb);
            end
         end
      end
   end

   initial begin
      int xe, ye, bx, by;
      int wait_cnt;
      reset = 1'b1; bus.Start = 1'b0; bus.Ack = 1'b0;
      bus.X_Edge = '0; bus.Y_Edge = '0; bus.Bird_X = '0; bus.Bird_Y = '0;

      // Reset and start handshakes with a pipe far away.
      repeat (5) drive(1, 0, 0, 600, 200, 320, 240);
      repeat (2) drive(0, 0, 0, 600, 200, 320, 240);
      drive(0, 1, 0, 600, 200, 320, 240);
      repeat (2) drive(0, 0, 0, 600, 200, 320, 240);
      drive(1, 0, 0, 600, 200, 320, 240);
      repeat (3) drive(0, 1, 0, 600, 200, 320, 240);
      repeat (2) drive(0, 0, 0, 600, 200, 320, 240);

      // Pipe scrolls into a bird sitting above the gap.
      for (int x = 350; x >= 335; x--) drive(0, 0, 0, x, 270, 320, 240);
      repeat (3) drive(0, 0, 0, 334, 270, 320, 240);
      drive(0, 1, 0, 334, 270, 320, 240);
      drive(0, 0, 1, 600, 270, 320, 240);
      drive(0, 0, 0, 600, 270, 320, 240);

      // Safely inside the gap, including both exact gap boundaries.
      drive(0, 1, 0, 300, 270, 320, 300);
      repeat (2) drive(0, 0, 0, 300, 270, 320, 300);
      drive(0, 0, 1, 300, 270, 320, 270);
      drive(0, 1, 0, 300, 270, 320, 374);
      drive(0, 0, 0, 300, 270, 320, 375);
      drive(0, 0, 1, 600, 270, 320, 240);
      drive(0, 0, 0, 600, 270, 320, 240);

      // Off the top of the screen with no pipe nearby, then reset mid-game.
      drive(0, 1, 0, 600, 270, 320, 240);
      drive(0, 0, 0, 600, 270, 320, -5);
      drive(0, 0, 0, 600, 270, 320, 240);
      drive(0, 0, 1, 600, 270, 320, 240);
      drive(0, 1, 0, 600, 270, 320, 470);
      drive(0, 1, 0, 600, 270, 320, 464);
      drive(1, 0, 0, 600, 270, 320, 240);
      drive(0, 0, 0, 1000, 950, 320, 240);

      for (int i = 0; i < 1500; i++) begin
         xe = $urandom_range(0, 1023);
         ye = $urandom_range(0, 420);
         if ($urandom_range(0, 1) == 1) begin
            by = ye + $urandom_range(0, 110);
            bx = xe + $urandom_range(0, 140) - 70;
         end else begin
            by = $urandom_range(0, 520) - 20;
            bx = $urandom_range(0, 1023);
         end
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0, xe, ye, bx, by);
      end

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 20) begin
         @(posedge Clk);
         wait_cnt++;
      end
      #2;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
